fifo_uart_tx: RTL

Parametrised UART transmitter that drains the Ethernet-receive byte FIFO on its read side, replacing the tied-off `rd_en`. It lives in the 100 MHz UART clock domain. It pops one byte at a time from a standard-mode (non-FWFT) FIFO and serialises it LSB-first. Data width, parity, stop bits and bit period are configurable, and it keeps a frame counter for debug.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/fifo_uart_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes
// and the default bit period for a 100 MHz clock at 115200 baud.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a standard-mode byte FIFO: pops one byte,
// serialises it LSB-first with optional parity and 1 or 2 stop bits.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic        uart_tx_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        uart_txd,
    output logic        busy,
    output logic [15:0] frame_count
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("fifo_uart_tx: DATA_BITS must be in 5..8");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("fifo_uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    uart_tx_state_t         state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_bit;
    logic [DATA_BITS-1:0]   rx_byte;
    logic                   bit_done;

    assign rx_byte  = fifo_dout[DATA_BITS-1:0];
    assign bit_done = (bit_cnt == CNT_LAST);

    always_ff @(posedge uart_tx_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            par_bit     <= 1'b0;
            uart_txd    <= 1'b1;
            fifo_rd_en  <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The cycle carrying the pop strobe is still IDLE; the byte
                    // arrives one cycle later, so LATCH follows the strobe.
                    if (fifo_rd_en) begin
                        state <= ST_LATCH;
                    end else if (enable && !fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    shift_reg <= rx_byte;
                    par_bit   <= (PARITY == PAR_ODD) ? ~^rx_byte : ^rx_byte;
                    uart_txd  <= 1'b0;
                    bit_cnt   <= '0;
                    bit_idx   <= '0;
                    state     <= ST_START;
                end
                ST_START: begin
                    if (bit_done) begin
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        uart_txd  <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != PAR_NONE) begin
                                uart_txd <= par_bit;
                                state    <= ST_PARITY;
                            end else begin
                                uart_txd <= 1'b1;
                                state    <= ST_STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            uart_txd  <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        uart_txd <= 1'b1;
                        state    <= ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx     <= '0;
                            state       <= ST_IDLE;
                            frame_count <= frame_count + 16'd1;
                            // Pop decision is taken on the way back to IDLE so the
                            // strobe lands in the first IDLE cycle (N+2 frame pitch).
                            if (enable && !fifo_empty) begin
                                fifo_rd_en <= 1'b1;
                            end else begin
                                busy <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    uart_txd <= 1'b1;
                    busy     <= 1'b0;
                    bit_cnt  <= '0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

endmodule
